// File: rtl/coeff_token_dec.sv
// coeff_token_dec: bit-serial CAVLC coeff_token decoder (VLC0/VLC1/VLC2 tables and 6-bit FLC).
// Takes one bit per bit_valid&&bit_ready handshake, MSB first, and pulses done with T1/TotalCoeff/length.
module coeff_token_dec #(
   parameter int MAXLEN = 16,
   parameter int FLCLEN = 6
) (
   input  logic       clk_n,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] nC,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic       bit_ready,
   output logic       done,
   output logic       err,
   output logic [1:0] T1,
   output logic [4:0] NZQs,
   output logic [4:0] codeLen
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   // Entry = {length[4:0], code value[3:0]} at index TotalCoeff*4+TrailingOnes; every codeword's value fits
   // in 4 bits once its leading zeros are carried by the length. Length 0 marks an illegal pair.
   localparam logic [8:0] VLC0 [68] = '{
      9'h011, 9'h000, 9'h000, 9'h000,  9'h065, 9'h021, 9'h000, 9'h000,
      9'h087, 9'h064, 9'h031, 9'h000,  9'h097, 9'h086, 9'h075, 9'h053,
      9'h0a7, 9'h096, 9'h085, 9'h063,  9'h0b7, 9'h0a6, 9'h095, 9'h074,
      9'h0df, 9'h0b6, 9'h0a5, 9'h084,  9'h0db, 9'h0de, 9'h0b5, 9'h094,
      9'h0d8, 9'h0da, 9'h0dd, 9'h0a4,  9'h0ef, 9'h0ee, 9'h0d9, 9'h0b4,
      9'h0eb, 9'h0ea, 9'h0ed, 9'h0dc,  9'h0ff, 9'h0fe, 9'h0e9, 9'h0ec,
      9'h0fb, 9'h0fa, 9'h0fd, 9'h0e8,  9'h10f, 9'h0f1, 9'h0f9, 9'h0fc,
      9'h10b, 9'h10e, 9'h10d, 9'h0f8,  9'h107, 9'h10a, 9'h109, 9'h10c,
      9'h104, 9'h106, 9'h105, 9'h108};
   localparam logic [8:0] VLC1 [68] = '{
      9'h023, 9'h000, 9'h000, 9'h000,  9'h06b, 9'h022, 9'h000, 9'h000,
      9'h067, 9'h057, 9'h033, 9'h000,  9'h077, 9'h06a, 9'h069, 9'h045,
      9'h087, 9'h066, 9'h065, 9'h044,  9'h084, 9'h076, 9'h075, 9'h056,
      9'h097, 9'h086, 9'h085, 9'h068,  9'h0bf, 9'h096, 9'h095, 9'h064,
      9'h0bb, 9'h0be, 9'h0bd, 9'h074,  9'h0cf, 9'h0ba, 9'h0b9, 9'h094,
      9'h0cb, 9'h0ce, 9'h0cd, 9'h0bc,  9'h0c8, 9'h0ca, 9'h0c9, 9'h0b8,
      9'h0df, 9'h0de, 9'h0dd, 9'h0cc,  9'h0db, 9'h0da, 9'h0d9, 9'h0dc,
      9'h0d7, 9'h0eb, 9'h0d6, 9'h0d8,  9'h0e9, 9'h0e8, 9'h0ea, 9'h0d1,
      9'h0e7, 9'h0e6, 9'h0e5, 9'h0e4};
   localparam logic [8:0] VLC2 [68] = '{
      9'h04f, 9'h000, 9'h000, 9'h000,  9'h06f, 9'h04e, 9'h000, 9'h000,
      9'h06b, 9'h05f, 9'h04d, 9'h000,  9'h068, 9'h05c, 9'h05e, 9'h04c,
      9'h07f, 9'h05a, 9'h05b, 9'h04b,  9'h07b, 9'h058, 9'h059, 9'h04a,
      9'h079, 9'h06e, 9'h06d, 9'h049,  9'h078, 9'h06a, 9'h069, 9'h048,
      9'h08f, 9'h07e, 9'h07d, 9'h05d,  9'h08b, 9'h08e, 9'h07a, 9'h06c,
      9'h09f, 9'h08a, 9'h08d, 9'h07c,  9'h09b, 9'h09e, 9'h089, 9'h08c,
      9'h098, 9'h09a, 9'h09d, 9'h088,  9'h0ad, 9'h097, 9'h099, 9'h09c,
      9'h0a9, 9'h0ac, 9'h0ab, 9'h0aa,  9'h0a5, 9'h0a8, 9'h0a7, 9'h0a6,
      9'h0a1, 9'h0a4, 9'h0a3, 9'h0a2};

   state_t            r_state;
   logic [1:0]        r_tab;
   logic [MAXLEN-2:0] r_shreg;
   logic [4:0]        r_len;
   logic              r_ready;
   logic              r_done;
   logic              r_err;
   logic [1:0]        r_t1;
   logic [4:0]        r_tc;
   logic [4:0]        r_code_len;
   logic [MAXLEN-1:0] w_next;
   logic [8:0]        w_ent;
   logic [4:0]        w_nlen;
   logic [4:0]        w_flc_tc;
   logic [4:0]        w_vlc_tc;
   logic [4:0]        w_tc;
   logic [1:0]        w_vlc_t1;
   logic [1:0]        w_t1;
   logic              w_hit;
   logic              w_flc;
   logic              w_flc_esc;
   logic              w_flc_bad;
   logic              w_zero;
   logic              w_fin;
   logic              w_err;

   function automatic logic [8:0] entry(input logic [1:0] tab, input int i);
      return tab == 2'd0 ? VLC0[i] : tab == 2'd1 ? VLC1[i] : VLC2[i];
   endfunction

   assign w_next    = {r_shreg, bit_in};
   assign w_nlen    = (r_len == 5'(MAXLEN)) ? r_len : r_len + 5'd1;
   assign w_flc     = r_tab == 2'd3;
   assign w_flc_esc = w_next[5:0] == 6'b000011;
   assign w_flc_tc  = {1'b0, w_next[5:2]} + 5'd1;
   assign w_flc_bad = !w_flc_esc && ({3'b000, w_next[1:0]} > w_flc_tc);

   always_comb begin
      w_hit    = 1'b0;
      w_vlc_t1 = 2'd0;
      w_vlc_tc = 5'd0;
      w_ent    = 9'd0;
      for (int i = 0; i < 68; i++) begin
         w_ent = entry(r_tab, i);
         if (w_ent[8:4] == w_nlen && w_next == {{(MAXLEN-4){1'b0}}, w_ent[3:0]}) begin
            w_hit    = 1'b1;
            w_vlc_t1 = i[1:0];
            w_vlc_tc = 5'(i / 4);
         end
      end
   end

   assign w_fin  = w_flc ? (w_nlen == 5'(FLCLEN)) : (w_hit || w_nlen == 5'(MAXLEN));
   assign w_err  = w_flc ? w_flc_bad : !w_hit;
   assign w_zero = w_err || (w_flc && w_flc_esc);
   assign w_t1   = w_zero ? 2'd0 : w_flc ? w_next[1:0] : w_vlc_t1;
   assign w_tc   = w_zero ? 5'd0 : w_flc ? w_flc_tc : w_vlc_tc;

   always_ff @(posedge clk_n) begin
      if (rst) begin
         r_state    <= IDLE;
         r_tab      <= 2'd0;
         r_shreg    <= '0;
         r_len      <= 5'd0;
         r_ready    <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_t1       <= 2'd0;
         r_tc       <= 5'd0;
         r_code_len <= 5'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (start) begin
               r_state <= SHIFT;
               r_tab   <= nC[3] ? 2'd3 : nC[2] ? 2'd2 : nC[1] ? 2'd1 : 2'd0;
               r_shreg <= '0;
               r_len   <= 5'd0;
               r_ready <= 1'b1;
            end
            SHIFT: if (bit_valid) begin
               r_shreg <= w_next[MAXLEN-2:0];
               r_len   <= w_nlen;
               if (w_fin) begin
                  r_state    <= DONE;
                  r_ready    <= 1'b0;
                  r_done     <= 1'b1;
                  r_err      <= w_err;
                  r_t1       <= w_t1;
                  r_tc       <= w_tc;
                  r_code_len <= w_nlen;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bit_ready = r_ready;
   assign done      = r_done;
   assign err       = r_err;
   assign T1        = r_t1;
   assign NZQs      = r_tc;
   assign codeLen   = r_code_len;
endmodule

// File: tb/tb_coeff_token_dec.sv
// tb_coeff_token_dec: directed and random decodes checked against a string-table reference model.
module tb_coeff_token_dec;
   logic       clk_n = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic [3:0] nC = 4'd0;
   logic       bit_ready;
   logic       done;
   logic       err;
   logic [1:0] T1;
   logic [4:0] NZQs;
   logic [4:0] codeLen;
   int         checks = 0;
   int         errors = 0;

   // Codewords indexed by TotalCoeff*4+TrailingOnes; "" marks an illegal pair.
   string vlc0 [68] = '{
      "1", "", "", "",
      "000101", "01", "", "",
      "00000111", "000100", "001", "",
      "000000111", "00000110", "0000101", "00011",
      "0000000111", "000000110", "00000101", "000011",
      "00000000111", "0000000110", "000000101", "0000100",
      "0000000001111", "00000000110", "0000000101", "00000100",
      "0000000001011", "0000000001110", "00000000101", "000000100",
      "0000000001000", "0000000001010", "0000000001101", "0000000100",
      "00000000001111", "00000000001110", "0000000001001", "00000000100",
      "00000000001011", "00000000001010", "00000000001101", "0000000001100",
      "000000000001111", "000000000001110", "00000000001001", "00000000001100",
      "000000000001011", "000000000001010", "000000000001101", "00000000001000",
      "0000000000001111", "000000000000001", "000000000001001", "000000000001100",
      "0000000000001011", "0000000000001110", "0000000000001101", "000000000001000",
      "0000000000000111", "0000000000001010", "0000000000001001", "0000000000001100",
      "0000000000000100", "0000000000000110", "0000000000000101", "0000000000001000"};
   string vlc1 [68] = '{
      "11", "", "", "",
      "001011", "10", "", "",
      "000111", "00111", "011", "",
      "0000111", "001010", "001001", "0101",
      "00000111", "000110", "000101", "0100",
      "00000100", "0000110", "0000101", "00110",
      "000000111", "00000110", "00000101", "001000",
      "00000001111", "000000110", "000000101", "000100",
      "00000001011", "00000001110", "00000001101", "0000100",
      "000000001111", "00000001010", "00000001001", "000000100",
      "000000001011", "000000001110", "000000001101", "00000001100",
      "000000001000", "000000001010", "000000001001", "00000001000",
      "0000000001111", "0000000001110", "0000000001101", "000000001100",
      "0000000001011", "0000000001010", "0000000001001", "0000000001100",
      "0000000000111", "00000000001011", "0000000000110", "0000000001000",
      "00000000001001", "00000000001000", "00000000001010", "0000000000001",
      "00000000000111", "00000000000110", "00000000000101", "00000000000100"};
   string vlc2 [68] = '{
      "1111", "", "", "",
      "001111", "1110", "", "",
      "001011", "01111", "1101", "",
      "001000", "01100", "01110", "1100",
      "0001111", "01010", "01011", "1011",
      "0001011", "01000", "01001", "1010",
      "0001001", "001110", "001101", "1001",
      "0001000", "001010", "001001", "1000",
      "00001111", "0001110", "0001101", "01101",
      "00001011", "00001110", "0001010", "001100",
      "000001111", "00001010", "00001101", "0001100",
      "000001011", "000001110", "00001001", "00001100",
      "000001000", "000001010", "000001101", "00001000",
      "0000001101", "000000111", "000001001", "000001100",
      "0000001001", "0000001100", "0000001011", "0000001010",
      "0000000101", "0000001000", "0000000111", "0000000110",
      "0000000001", "0000000100", "0000000011", "0000000010"};

   coeff_token_dec dut (
      .clk_n(clk_n), .rst(rst), .start(start), .nC(nC), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready), .done(done), .err(err), .T1(T1), .NZQs(NZQs), .codeLen(codeLen));

   always #5 clk_n = ~clk_n;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int tabof(input int nc);
      return nc < 2 ? 0 : nc < 4 ? 1 : 2;
   endfunction

   function automatic string cw(input int tab, input int i);
      return tab == 0 ? vlc0[i] : tab == 1 ? vlc1[i] : vlc2[i];
   endfunction

   function automatic logic [31:0] to_bits(input string b);
      logic [31:0] s = '0;
      for (int k = 0; k < b.len(); k++) s[31-k] = (b[k] == "1");
      return s;
   endfunction

   // Reads bits MSB-first from s until a table codeword equals the bits read so far.
   task automatic model(input int nc, input logic [31:0] s, output int len, output int t1, output int tc, output bit e);
      string acc;
      int v;
      int tab;
      acc = "";
      tab = tabof(nc);
      if (nc >= 8) begin
         v = int'(s[31:26]);
         len = 6;
         if (v == 3) begin
            tc = 0;
            t1 = 0;
            e = 1'b0;
         end else begin
            tc = v / 4 + 1;
            t1 = v % 4;
            e = t1 > tc;
            if (e) begin
               tc = 0;
               t1 = 0;
            end
         end
      end else begin
         len = 16;
         t1 = 0;
         tc = 0;
         e = 1'b1;
         for (int k = 0; k < 16; k++) begin
            if (s[31-k]) acc = {acc, "1"};
            else acc = {acc, "0"};
            for (int i = 0; i < 68; i++)
               if (cw(tab, i) == acc) begin
                  len = k + 1;
                  t1 = i % 4;
                  tc = i / 4;
                  e = 1'b0;
               end
            if (!e) break;
         end
      end
   endtask

   task automatic run(input string tag, input int nc, input logic [31:0] s, input int mode, input int start_at);
      int len, t1, tc, cons, cyc;
      bit e, pulsed;
      model(nc, s, len, t1, tc, e);
      @(negedge clk_n);
      chk({tag, ".idle_ready"}, 16'(bit_ready), 16'd0);
      start = 1'b1;
      nC = 4'(nc);
      bit_valid = 1'b1;
      bit_in = 1'($urandom);
      @(negedge clk_n);
      start = 1'b0;
      nC = 4'($urandom);
      cons = 0;
      cyc = 0;
      pulsed = 1'b0;
      while (cons < len && cyc < 400) begin
         chk({tag, ".busy_done"}, 16'(done), 16'd0);
         chk({tag, ".busy_ready"}, 16'(bit_ready), 16'd1);
         bit_valid = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom);
         bit_in = s[31-cons];
         start = !pulsed && cons == start_at;
         if (start) begin
            pulsed = 1'b1;
            nC = 4'd9;
         end
         if (bit_valid) cons++;
         cyc++;
         @(negedge clk_n);
         start = 1'b0;
      end
      chk({tag, ".bits_consumed"}, 16'(cons), 16'(len));
      bit_valid = 1'b1;
      bit_in = 1'($urandom);
      chk({tag, ".done"}, 16'(done), 16'd1);
      chk({tag, ".done_ready"}, 16'(bit_ready), 16'd0);
      chk({tag, ".err"}, 16'(err), 16'(e));
      chk({tag, ".T1"}, 16'(T1), 16'(t1));
      chk({tag, ".NZQs"}, 16'(NZQs), 16'(tc));
      chk({tag, ".codeLen"}, 16'(codeLen), 16'(len));
      @(negedge clk_n);
      bit_valid = 1'b0;
      chk({tag, ".done_pulse"}, 16'(done), 16'd0);
      chk({tag, ".after_ready"}, 16'(bit_ready), 16'd0);
      chk({tag, ".hold_len"}, 16'(codeLen), 16'(len));
      chk({tag, ".hold_nzqs"}, 16'(NZQs), 16'(tc));
   endtask

   task automatic expect_out(input string tag, input int e, input int t1, input int tc, input int len);
      chk({tag, ".k_err"}, 16'(err), 16'(e));
      chk({tag, ".k_T1"}, 16'(T1), 16'(t1));
      chk({tag, ".k_NZQs"}, 16'(NZQs), 16'(tc));
      chk({tag, ".k_codeLen"}, 16'(codeLen), 16'(len));
   endtask

   initial begin
      int nc, i;
      logic [31:0] s;
      string c;
      repeat (2) @(negedge clk_n);
      chk("rst.ready", 16'(bit_ready), 16'd0);
      chk("rst.done", 16'(done), 16'd0);
      expect_out("rst", 0, 0, 0, 0);
      rst = 1'b0;
      run("vlc0_1", 0, to_bits("1"), 0, -1);
      expect_out("vlc0_1", 0, 0, 0, 1);
      run("vlc0_00011", 0, to_bits("00011"), 0, -1);
      expect_out("vlc0_00011", 0, 3, 3, 5);
      run("vlc1_toggle", 2, to_bits("001011"), 1, -1);
      expect_out("vlc1_toggle", 0, 0, 1, 6);
      run("vlc2_1100", 5, to_bits("1100"), 0, -1);
      expect_out("vlc2_1100", 0, 3, 3, 4);
      run("flc_zero", 15, to_bits("000011"), 0, -1);
      expect_out("flc_zero", 0, 0, 0, 6);
      run("flc_16", 8, to_bits("111111"), 0, -1);
      expect_out("flc_16", 0, 3, 16, 6);
      run("flc_bad", 9, to_bits("000010"), 2, -1);
      expect_out("flc_bad", 1, 0, 0, 6);
      run("flc_bad2", 12, to_bits("000111"), 0, -1);
      expect_out("flc_bad2", 1, 0, 0, 6);
      run("vlc0_zeros", 0, 32'h0, 0, -1);
      expect_out("vlc0_zeros", 1, 0, 0, 16);
      run("start_ignored", 0, to_bits("00000111"), 0, 3);
      expect_out("start_ignored", 0, 0, 2, 8);
      start = 1'b1;
      nC = 4'd0;
      @(negedge clk_n);
      start = 1'b0;
      bit_valid = 1'b1;
      bit_in = 1'b0;
      repeat (2) @(negedge clk_n);
      bit_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk_n);
      rst = 1'b0;
      chk("abort.ready", 16'(bit_ready), 16'd0);
      chk("abort.done", 16'(done), 16'd0);
      expect_out("abort", 0, 0, 0, 0);
      repeat (3) begin
         @(negedge clk_n);
         chk("abort.no_done", 16'(done), 16'd0);
         chk("abort.idle_ready", 16'(bit_ready), 16'd0);
      end
      run("vlc0_01", 0, to_bits("01"), 0, -1);
      expect_out("vlc0_01", 0, 1, 1, 2);
      repeat (250) begin
         nc = int'($urandom_range(0, 15));
         if (nc < 8 && $urandom_range(0, 1) == 1) begin
            do i = int'($urandom_range(0, 67)); while (cw(tabof(nc), i) == "");
            c = cw(tabof(nc), i);
            s = to_bits(c) | ($urandom >> c.len());
         end else begin
            s = $urandom >> $urandom_range(0, 15);
         end
         run("rand", nc, s, 2, $urandom_range(0, 1) == 1 ? int'($urandom_range(0, 5)) : -1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
